// File: rtl/time_uart_reporter.sv
// Serialises a snapshot of the four clock digits as the ASCII frame "DD:DD\r\n" on an 8N1 UART.
// One frame per accepted SEND; a SEND that arrives during a frame is dropped and flagged on OVERRUN.
module time_uart_reporter #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600,
    parameter int CNT_W  = 13
) (
    input  logic       M_CLOCK,
    input  logic       M_RESET,
    input  logic [2:0] DIGIT_ONE,
    input  logic [3:0] DIGIT_TWO,
    input  logic [2:0] DIGIT_THREE,
    input  logic [3:0] DIGIT_FOUR,
    input  logic       SEND,
    output logic       TX,
    output logic       BUSY,
    output logic       FRAME_DONE,
    output logic       OVERRUN
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_r;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [2:0]       bit_idx_r;
    logic [2:0]       byte_idx_r;
    logic [7:0]       shift_r;
    logic [15:0]      snap_r;
    logic             tx_r;
    logic             busy_r;
    logic             frame_done_r;
    logic             overrun_r;
    logic [7:0]       cur_byte_s;
    logic             bit_end_s;

    // Out-of-range digits are shown as '?' so a corrupt core value is visible on the terminal.
    function automatic logic [7:0] digit_ascii(input logic [3:0] d, input logic [3:0] max_d);
        logic [7:0] c;
        if (d > max_d) begin
            c = 8'h3F;
        end else begin
            c = 8'h30 + {4'h0, d};
        end
        return c;
    endfunction

    // Character of the frame currently being sent, taken only from the snapshot.
    always_comb begin
        cur_byte_s = 8'h3F;
        case (byte_idx_r)
            3'd0:    cur_byte_s = digit_ascii(snap_r[15:12], 4'd6);
            3'd1:    cur_byte_s = digit_ascii(snap_r[11:8], 4'd9);
            3'd2:    cur_byte_s = 8'h3A;
            3'd3:    cur_byte_s = digit_ascii(snap_r[7:4], 4'd5);
            3'd4:    cur_byte_s = digit_ascii(snap_r[3:0], 4'd9);
            3'd5:    cur_byte_s = 8'h0D;
            3'd6:    cur_byte_s = 8'h0A;
            default: cur_byte_s = 8'h3F;
        endcase
    end

    assign bit_end_s = (baud_cnt_r == LAST_CNT);

    // Frame sequencer: bit timing, byte stepping and all registered outputs.
    always_ff @(posedge M_CLOCK) begin
        if (M_RESET) begin
            state_r      <= IDLE;
            baud_cnt_r   <= '0;
            bit_idx_r    <= 3'd0;
            byte_idx_r   <= 3'd0;
            shift_r      <= 8'h00;
            snap_r       <= 16'h0000;
            tx_r         <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            overrun_r    <= SEND && busy_r;
            case (state_r)
                IDLE: begin
                    tx_r <= 1'b1;
                    if (SEND) begin
                        snap_r     <= {1'b0, DIGIT_ONE, DIGIT_TWO, 1'b0, DIGIT_THREE, DIGIT_FOUR};
                        state_r    <= START;
                        tx_r       <= 1'b0;
                        busy_r     <= 1'b1;
                        baud_cnt_r <= '0;
                        bit_idx_r  <= 3'd0;
                        byte_idx_r <= 3'd0;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= '0;
                        state_r    <= DATA;
                        bit_idx_r  <= 3'd0;
                        tx_r       <= cur_byte_s[0];
                        shift_r    <= {1'b0, cur_byte_s[7:1]};
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= '0;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= shift_r[0];
                            shift_r   <= {1'b0, shift_r[7:1]};
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= '0;
                        if (byte_idx_r == 3'd6) begin
                            state_r      <= IDLE;
                            busy_r       <= 1'b0;
                            frame_done_r <= 1'b1;
                        end else begin
                            byte_idx_r <= byte_idx_r + 3'd1;
                            state_r    <= START;
                            tx_r       <= 1'b0;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign TX         = tx_r;
    assign BUSY       = busy_r;
    assign FRAME_DONE = frame_done_r;
    assign OVERRUN    = overrun_r;

endmodule
